// File: rtl/mem_write_checker.sv
// mem_write_checker: ordered store-sequence checker with tolerated window, timeout and latched status
module mem_write_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1024,
  parameter logic [ADDR_W-1:0] IGN_LO = 'h60,
  parameter logic [ADDR_W-1:0] IGN_HI = 'h60,
  localparam int NW = $clog2(DEPTH+1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(TIMEOUT+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NW-1:0]     num_exp,
  input  logic              ld_en,
  input  logic [IW-1:0]     ld_idx,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [NW-1:0]     match_cnt,
  output logic [7:0]        ign_cnt,
  output logic [CW-1:0]     cycle_cnt,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_ADDR = 3'd1;
  localparam logic [2:0] C_DATA = 3'd2;
  localparam logic [2:0] C_TMO  = 3'd3;
  localparam logic [2:0] C_CFG  = 3'd4;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NW-1:0] num_q, num_d;
  logic [NW-1:0] match_cnt_q, match_cnt_d;
  logic [7:0] ign_cnt_q, ign_cnt_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0] fail_code_q, fail_code_d;
  logic [ADDR_W-1:0] fail_adr_q, fail_adr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [ADDR_W-1:0] tab_adr_q [DEPTH];
  logic [DATA_W-1:0] tab_dat_q [DEPTH];
  logic hit_adr, hit_dat, in_win, last, tmo, ld_ok;
  assign hit_adr = mem_write && (data_adr == tab_adr_q[ptr_q]);
  assign hit_dat = write_data == tab_dat_q[ptr_q];
  assign in_win = (data_adr >= IGN_LO) && (data_adr <= IGN_HI);
  assign last = (match_cnt_q + NW'(1)) == num_q;
  assign tmo = cycle_cnt_q == CW'(TIMEOUT-1);
  assign ld_ok = ld_en && (state_q != S_RUN) && (32'(ld_idx) < DEPTH);
  // Expected-write table; frozen while a check is running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_adr_q[i] <= '0;
        tab_dat_q[i] <= '0;
      end
    end else if (ld_ok) begin
      tab_adr_q[ld_idx] <= ld_addr;
      tab_dat_q[ld_idx] <= ld_data;
    end
  end
  // State and diagnostic registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      num_q <= '0;
      match_cnt_q <= '0;
      ign_cnt_q <= '0;
      cycle_cnt_q <= '0;
      fail_code_q <= C_NONE;
      fail_adr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      num_q <= num_d;
      match_cnt_q <= match_cnt_d;
      ign_cnt_q <= ign_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      fail_code_q <= fail_code_d;
      fail_adr_q <= fail_adr_d;
      fail_data_q <= fail_data_d;
    end
  end
  // Arm on start, then classify each store; pass/fail outrank the timeout on the same edge
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    num_d = num_q;
    match_cnt_d = match_cnt_q;
    ign_cnt_d = ign_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    fail_code_d = fail_code_q;
    fail_adr_d = fail_adr_q;
    fail_data_d = fail_data_q;
    if (state_q != S_RUN && start) begin
      ptr_d = '0;
      match_cnt_d = '0;
      ign_cnt_d = '0;
      cycle_cnt_d = '0;
      fail_code_d = C_NONE;
      fail_adr_d = '0;
      fail_data_d = '0;
      if (num_exp == '0) begin
        state_d = S_PASS;
      end else if (32'(num_exp) > DEPTH) begin
        state_d = S_FAIL;
        fail_code_d = C_CFG;
      end else begin
        state_d = S_RUN;
        num_d = num_exp;
      end
    end else if (state_q == S_RUN) begin
      if (hit_adr && hit_dat) begin
        ptr_d = ptr_q + IW'(1);
        match_cnt_d = match_cnt_q + NW'(1);
        state_d = last ? S_PASS : S_RUN;
      end else if (mem_write && in_win) begin
        ign_cnt_d = (ign_cnt_q == 8'hFF) ? ign_cnt_q : ign_cnt_q + 8'd1;
      end else if (mem_write) begin
        state_d = S_FAIL;
        fail_code_d = hit_adr ? C_DATA : C_ADDR;
        fail_adr_d = data_adr;
        fail_data_d = write_data;
      end
      if (state_d == S_RUN && tmo) begin
        state_d = S_FAIL;
        fail_code_d = C_TMO;
      end
      cycle_cnt_d = (state_d == S_RUN) ? cycle_cnt_q + CW'(1) : cycle_cnt_q;
    end
  end
  assign busy = state_q == S_RUN;
  assign pass = state_q == S_PASS;
  assign fail = state_q == S_FAIL;
  assign done = pass || fail;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign ign_cnt = ign_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
  assign fail_adr = fail_adr_q;
  assign fail_data = fail_data_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: scoreboard bench for mem_write_checker with a sequence-level reference model
module tb_mem_write_checker;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  localparam logic [31:0] ILO = 32'h60;
  localparam logic [31:0] IHI = 32'h60;
  typedef struct packed {
    logic p;
    logic [2:0] code;
    logic [2:0] mc;
    logic [7:0] ic;
    logic [4:0] cc;
    logic [31:0] fa;
    logic [31:0] fd;
  } exp_t;
  logic clk = 1'b0;
  logic reset, start, ld_en, mem_write;
  logic [2:0] num_exp;
  logic [1:0] ld_idx;
  logic [31:0] ld_addr, ld_data, data_adr, write_data;
  logic busy, done, pass, fail;
  logic [2:0] fail_code, match_cnt;
  logic [7:0] ign_cnt;
  logic [4:0] cycle_cnt;
  logic [31:0] fail_adr, fail_data;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t me;
  logic done_p, start_p;
  logic [31:0] t_adr [DEPTH];
  logic [31:0] t_dat [DEPTH];
  logic w_en [TO];
  logic [31:0] w_adr [TO];
  logic [31:0] w_dat [TO];
  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TO), .IGN_LO(ILO), .IGN_HI(IHI)) dut (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_cnt(match_cnt), .ign_cnt(ign_cnt), .cycle_cnt(cycle_cnt),
    .fail_adr(fail_adr), .fail_data(fail_data)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, b);
    end
  endfunction
  // Walks the store list slot by slot: kt is the slot on which the run ends, -1 if it never runs
  function automatic exp_t model(input int num, output int kt);
    exp_t e;
    int p;
    e = '0;
    p = 0;
    kt = -1;
    if (num == 0) begin
      e.p = 1'b1;
      return e;
    end
    if (num > DEPTH) begin
      e.code = 3'd4;
      return e;
    end
    for (int k = 0; k < TO; k++) begin
      if (w_en[k] && w_adr[k] == t_adr[p] && w_dat[k] == t_dat[p]) begin
        p++;
        e.mc = e.mc + 3'd1;
        if (p == num) begin
          e.p = 1'b1;
          e.cc = 5'(k);
          kt = k;
          return e;
        end
      end else if (w_en[k] && w_adr[k] >= ILO && w_adr[k] <= IHI) begin
        if (e.ic != 8'hFF) e.ic = e.ic + 8'd1;
      end else if (w_en[k]) begin
        e.code = (w_adr[k] == t_adr[p]) ? 3'd2 : 3'd1;
        e.fa = w_adr[k];
        e.fd = w_dat[k];
        e.cc = 5'(k);
        kt = k;
        return e;
      end
      if (k == TO - 1) begin
        e.code = 3'd3;
        e.cc = 5'(k);
        kt = k;
        return e;
      end
    end
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_idx = 2'(idx);
    ld_addr = a;
    ld_data = d;
    t_adr[idx] = a;
    t_dat[idx] = d;
    tick();
    ld_en = 1'b0;
  endtask
  task automatic clear_w();
    for (int k = 0; k < TO; k++) begin
      w_en[k] = 1'b0;
      w_adr[k] = '0;
      w_dat[k] = '0;
    end
  endtask
  task automatic set_w(input int k, input logic [31:0] a, input logic [31:0] d);
    w_en[k] = 1'b1;
    w_adr[k] = a;
    w_dat[k] = d;
  endtask
  // Issues one check; a junk load and a num_exp=0 start are thrown in while the run is known to be live
  task automatic run_case(input int num);
    exp_t e;
    int kt;
    e = model(num, kt);
    exp_q.push_back(e);
    start = 1'b1;
    num_exp = 3'(num);
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    for (int k = 0; k < TO; k++) begin
      mem_write = w_en[k];
      data_adr = w_adr[k];
      write_data = w_dat[k];
      ld_en = (k == 1 && kt > 1);
      ld_idx = 2'($urandom_range(0, 3));
      ld_addr = $urandom;
      ld_data = $urandom;
      start = (k == 2 && kt > 2);
      num_exp = start ? 3'd0 : 3'(num);
      tick();
    end
    mem_write = 1'b0;
    ld_en = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_wait: got no done expected done within budget");
      exp_q.delete();
    end
  endtask
  // Monitor: each fresh done (rising, or re-entered after a start) retires one expectation
  initial begin
    done_p = 1'b0;
    start_p = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && done && (!done_p || start_p)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no result");
        end else begin
          me = exp_q.pop_front();
          chk("pass", 32'(pass), 32'(me.p));
          chk("fail", 32'(fail), 32'(!me.p));
          chk("busy", 32'(busy), 32'd0);
          chk("fail_code", 32'(fail_code), 32'(me.code));
          chk("match_cnt", 32'(match_cnt), 32'(me.mc));
          chk("ign_cnt", 32'(ign_cnt), 32'(me.ic));
          chk("cycle_cnt", 32'(cycle_cnt), 32'(me.cc));
          chk("fail_adr", fail_adr, me.fa);
          chk("fail_data", fail_data, me.fd);
        end
      end
      done_p = done;
      start_p = start;
    end
  end
  initial begin
    int r, num, gp;
    reset = 1'b0;
    start = 1'b0;
    ld_en = 1'b0;
    mem_write = 1'b0;
    num_exp = '0;
    ld_idx = '0;
    ld_addr = '0;
    ld_data = '0;
    data_adr = '0;
    write_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      t_adr[i] = '0;
      t_dat[i] = '0;
    end
    clear_w();
    repeat (3) tick();
    chk("rst_flags", {28'd0, busy, done, pass, fail}, 32'd0);
    chk("rst_counts", {13'd0, fail_code, match_cnt, ign_cnt, cycle_cnt}, 32'd0);
    chk("rst_fail_info", fail_adr | fail_data, 32'd0);
    reset = 1'b1;
    tick();
    load(0, 32'h64, 32'd7);
    clear_w();
    set_w(0, 32'h60, 32'd3);
    set_w(1, 32'h64, 32'd7);
    run_case(1);
    clear_w();
    set_w(0, 32'h64, 32'd6);
    run_case(1);
    load(0, 32'h10, 32'd1);
    load(1, 32'h14, 32'd2);
    ld_en = 1'b1;
    ld_idx = 2'd2;
    ld_addr = 32'h18;
    ld_data = 32'd3;
    t_adr[2] = 32'h18;
    t_dat[2] = 32'd3;
    clear_w();
    set_w(0, 32'h10, 32'd1);
    set_w(2, 32'h14, 32'd2);
    set_w(3, 32'h60, 32'd9);
    set_w(5, 32'h18, 32'd3);
    run_case(3);
    clear_w();
    set_w(0, 32'h18, 32'd3);
    run_case(3);
    clear_w();
    run_case(1);
    set_w(15, 32'h10, 32'd1);
    run_case(1);
    clear_w();
    set_w(15, 32'h60, 32'd1);
    run_case(2);
    run_case(5);
    run_case(7);
    run_case(0);
    run_case(0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DEPTH; i++) load(i, 32'($urandom_range(0, 31)) << 2, 32'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 19));
      num = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(5, 7)) : int'($urandom_range(1, 4));
      gp = 0;
      clear_w();
      for (int k = 0; k < TO; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 45) begin
          set_w(k, t_adr[gp], t_dat[gp]);
          gp = (gp + 1) % DEPTH;
        end else if (r < 60) set_w(k, 32'h60, $urandom);
        else if (r < 78) w_en[k] = 1'b0;
        else if (r < 88) set_w(k, t_adr[gp], t_dat[gp] ^ 32'd1);
        else if (r < 94) set_w(k, $urandom, $urandom);
        else w_en[k] = 1'b0;
      end
      run_case(num);
    end
    load(0, 32'h64, 32'd7);
    start = 1'b1;
    num_exp = 3'd1;
    tick();
    start = 1'b0;
    mem_write = 1'b1;
    data_adr = 32'h60;
    write_data = 32'd5;
    tick();
    mem_write = 1'b0;
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ign", 32'(ign_cnt), 32'd0);
    chk("mid_rst_cycle", 32'(cycle_cnt), 32'd0);
    chk("mid_rst_rest", {25'd0, done, pass, fail, fail_code, match_cnt}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      t_adr[i] = '0;
      t_dat[i] = '0;
    end
    clear_w();
    set_w(0, 32'h0, 32'h0);
    run_case(1);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
